// File: rtl/edp_diag_pkg.sv
// Shared types and constants for the EBOX data-path diagnostic sequencer.
package edp_diag_pkg;

    typedef enum logic {
        DIAG_READ    = 1'b0,
        DIAG_LOAD_AR = 1'b1
    } diagOp_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETTLE,
        CAPT,
        LOAD,
        RESP
    } seqState_t;

    localparam logic [2:0] SEL_AR  = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_MQ  = 3'd2;
    localparam logic [2:0] SEL_FM  = 3'd3;
    localparam logic [2:0] SEL_BRX = 3'd4;
    localparam logic [2:0] SEL_ARX = 3'd5;
    localparam logic [2:0] SEL_ADX = 3'd6;
    localparam logic [2:0] SEL_AD  = 3'd7;

endpackage

// File: rtl/edp_diag_seq_if.sv
// Host command/response, EBUS and DIAG/override signals of the diagnostic sequencer.
interface edp_diag_seq_if;

    logic        cmdValid;
    logic        cmdReady;
    logic        cmdOp;
    logic [2:0]  cmdSel;
    logic [0:35] cmdData;
    logic        rspValid;
    logic        rspReady;
    logic [0:35] rspData;
    logic        rspErr;
    logic        rspPar;
    logic        ebusReq;
    logic        ebusGrant;
    logic [0:35] ebusData;
    logic        diagRead12x;
    logic [2:0]  diagSel;
    logic        overrideAR;
    logic [0:35] arValue;

    modport master (
        input  cmdValid, cmdOp, cmdSel, cmdData, rspReady, ebusGrant, ebusData,
        output cmdReady, rspValid, rspData, rspErr, rspPar, ebusReq,
               diagRead12x, diagSel, overrideAR, arValue
    );

    modport slave (
        output cmdValid, cmdOp, cmdSel, cmdData, rspReady, ebusGrant, ebusData,
        input  cmdReady, rspValid, rspData, rspErr, rspPar, ebusReq,
               diagRead12x, diagSel, overrideAR, arValue
    );

endinterface

// File: rtl/edp_diag_timer.sv
// Saturating up-counter with clear; done flags when the count equals the terminal value.
module edp_diag_timer #(
    parameter int unsigned TW = 7
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] term,
    output logic          done
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == term);

endmodule

// File: rtl/edp_diag_seq.sv
// Host-side diagnostic sequencer: EBUS register reads via DIAG 12x and one-cycle AR loads.
module edp_diag_seq
    import edp_diag_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned GRANT_TMO  = 64
) (
    input  logic           clk,
    input  logic           resetN,
    edp_diag_seq_if.master bus
);

    localparam int unsigned MAX_CYC = (SETTLE_CYC > GRANT_TMO) ? SETTLE_CYC : GRANT_TMO;
    localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
    localparam logic [TW-1:0] SETTLE_TERM = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] GRANT_TERM  = TW'(GRANT_TMO - 1);

    seqState_t     state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [0:35]   data_q, data_d;
    logic [0:35]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          tmr_clr, tmr_en, tmr_done;
    logic [TW-1:0] tmr_term;

    edp_diag_timer #(.TW(TW)) u_timer (
        .clk    (clk),
        .resetN (resetN),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .term   (tmr_term),
        .done   (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_term   = GRANT_TERM;
        case (state_q)
            IDLE: begin
                if (bus.cmdValid) begin
                    sel_d   = bus.cmdSel;
                    data_d  = bus.cmdData;
                    tmr_clr = 1'b1;
                    state_d = (diagOp_t'(bus.cmdOp) == DIAG_LOAD_AR) ? LOAD : REQ;
                end
            end
            REQ: begin
                tmr_en = 1'b1;
                if (bus.ebusGrant) begin
                    tmr_clr = 1'b1;
                    state_d = SETTLE;
                end else if (tmr_done) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            // Grant is not re-checked here: once granted the bus stays ours until capture.
            SETTLE: begin
                tmr_en   = 1'b1;
                tmr_term = SETTLE_TERM;
                if (tmr_done) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                rsp_data_d = bus.ebusData;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            LOAD: begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rspReady) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.cmdReady    = (state_q == IDLE);
    assign bus.rspValid    = (state_q == RESP);
    assign bus.rspData     = rsp_data_q;
    assign bus.rspErr      = rsp_err_q;
    assign bus.rspPar      = ^rsp_data_q;
    assign bus.ebusReq     = (state_q == REQ) || (state_q == SETTLE) || (state_q == CAPT);
    assign bus.diagRead12x = (state_q == SETTLE) || (state_q == CAPT);
    assign bus.diagSel     = bus.diagRead12x ? sel_q : SEL_AR;
    assign bus.overrideAR  = (state_q == LOAD);
    assign bus.arValue     = (state_q == LOAD) ? data_q : '0;

endmodule

// File: tb/tb_edp_diag_seq.sv
// Scoreboard bench for edp_diag_seq: expected responses queued at issue, compared at handshake.
module tb_edp_diag_seq;
    import edp_diag_pkg::*;

    typedef struct {
        logic [0:35] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic resetN;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    edp_diag_seq_if bus ();

    edp_diag_seq #(
        .SETTLE_CYC (4),
        .GRANT_TMO  (64)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (resetN === 1'b1 && bus.rspValid === 1'b1 && bus.rspReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(bus.rspValid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 64'(bus.rspData), 64'(e.data));
                check("rsp_err", 64'(bus.rspErr), 64'(e.err));
                check("rsp_par", 64'(bus.rspPar), 64'(^e.data));
            end
        end
    end

    task automatic issue(input logic op, input logic [2:0] sel, input logic [0:35] data);
        for (int w = 0; w < 100 && bus.cmdReady !== 1'b1; w++) tick();
        check("cmd_ready", 64'(bus.cmdReady), 64'd1);
        bus.cmdValid = 1'b1;
        bus.cmdOp    = op;
        bus.cmdSel   = sel;
        bus.cmdData  = data;
        tick();
        bus.cmdValid = 1'b0;
        check("accepted", 64'(bus.cmdReady), 64'd0);
    endtask

    // Walks from the accept edge until rspValid; k counts edges after acceptance.
    task automatic run_rsp(input logic [2:0] sel, input logic [0:35] ar,
                           output int lat, output int diag_cyc, output int ovr_cyc);
        lat      = -1;
        diag_cyc = 0;
        ovr_cyc  = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.rspValid === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.diagRead12x === 1'b1) begin
                diag_cyc++;
                check("diag_sel", 64'(bus.diagSel), 64'(sel));
                check("diag_req", 64'(bus.ebusReq), 64'd1);
            end
            if (bus.overrideAR === 1'b1) begin
                ovr_cyc++;
                check("ar_value", 64'(bus.arValue), 64'(ar));
            end else begin
                check("ar_idle", 64'(bus.arValue), 64'd0);
            end
            tick();
        end
        if (lat < 0) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_rsp();
        bus.rspReady = 1'b1;
        tick();
        check("idle_ready", 64'(bus.cmdReady), 64'd1);
        check("idle_valid", 64'(bus.rspValid), 64'd0);
        check("idle_data", 64'(bus.rspData), 64'd0);
    endtask

    logic [2:0]  sels [8];
    logic [0:35] d;
    int lat, diag_cyc, ovr_cyc;

    initial begin
        sels = '{SEL_AR, SEL_BR, SEL_MQ, SEL_FM, SEL_BRX, SEL_ARX, SEL_ADX, SEL_AD};
        resetN        = 1'b0;
        bus.cmdValid  = 1'b1;
        bus.cmdOp     = 1'b0;
        bus.cmdSel    = SEL_BR;
        bus.cmdData   = '0;
        bus.rspReady  = 1'b1;
        bus.ebusGrant = 1'b1;
        bus.ebusData  = '0;

        // Reset with a command pending
        tick();
        tick();
        check("rst_cmd_ready", 64'(bus.cmdReady), 64'd1);
        check("rst_rsp_valid", 64'(bus.rspValid), 64'd0);
        check("rst_override", 64'(bus.overrideAR), 64'd0);
        check("rst_ebus_req", 64'(bus.ebusReq), 64'd0);
        check("rst_diag", 64'(bus.diagRead12x), 64'd0);
        bus.cmdValid = 1'b0;
        resetN       = 1'b1;
        tick();
        check("post_rst_req", 64'(bus.ebusReq), 64'd0);

        // READ MQ with immediate grant
        bus.ebusGrant = 1'b1;
        bus.ebusData  = 36'o123456_654321;
        exp_q.push_back('{data: 36'o123456_654321, err: 1'b0});
        issue(1'b0, SEL_MQ, '0);
        run_rsp(SEL_MQ, '0, lat, diag_cyc, ovr_cyc);
        check("read_lat", 64'(lat), 64'd6);
        check("read_diag_cyc", 64'(diag_cyc), 64'd5);
        check("read_ebus_rel", 64'(bus.ebusReq), 64'd0);
        finish_rsp();

        // READ with no grant: timeout
        bus.ebusGrant = 1'b0;
        bus.ebusData  = 36'o555555_555555;
        exp_q.push_back('{data: '0, err: 1'b1});
        issue(1'b0, SEL_AD, '0);
        run_rsp(SEL_AD, '0, lat, diag_cyc, ovr_cyc);
        check("tmo_lat", 64'(lat), 64'd64);
        check("tmo_diag_cyc", 64'(diag_cyc), 64'd0);
        finish_rsp();

        // LOAD_AR
        exp_q.push_back('{data: '0, err: 1'b0});
        issue(1'b1, SEL_AR, 36'o777777_000001);
        run_rsp(SEL_AR, 36'o777777_000001, lat, diag_cyc, ovr_cyc);
        check("load_ovr_cyc", 64'(ovr_cyc), 64'd1);
        check("load_lat", 64'(lat), 64'd1);
        check("load_ar_clear", 64'(bus.arValue), 64'd0);
        finish_rsp();

        // Backpressure with a second command held
        bus.ebusGrant = 1'b1;
        bus.ebusData  = 36'o101010_202020;
        bus.rspReady  = 1'b0;
        exp_q.push_back('{data: 36'o101010_202020, err: 1'b0});
        issue(1'b0, SEL_FM, '0);
        run_rsp(SEL_FM, '0, lat, diag_cyc, ovr_cyc);
        check("bp_lat", 64'(lat), 64'd6);
        exp_q.push_back('{data: '0, err: 1'b0});
        bus.cmdValid = 1'b1;
        bus.cmdOp    = 1'b1;
        bus.cmdData  = 36'o000123_456700;
        for (int i = 0; i < 10; i++) begin
            bus.ebusData = {$urandom(), 4'($urandom())};
            tick();
            check("bp_valid", 64'(bus.rspValid), 64'd1);
            check("bp_data", 64'(bus.rspData), 64'(36'o101010_202020));
            check("bp_cmd_ready", 64'(bus.cmdReady), 64'd0);
        end
        bus.rspReady = 1'b1;
        tick();
        check("bp_idle_ready", 64'(bus.cmdReady), 64'd1);
        check("bp_no_same_cyc", 64'(bus.overrideAR), 64'd0);
        tick();
        bus.cmdValid = 1'b0;
        check("bp_second_ovr", 64'(bus.overrideAR), 64'd1);
        check("bp_second_ar", 64'(bus.arValue), 64'(36'o000123_456700));
        tick();
        check("bp_second_rsp", 64'(bus.rspValid), 64'd1);
        finish_rsp();

        // Reset during SETTLE aborts without a response
        bus.ebusData = 36'o111111_222222;
        issue(1'b0, SEL_BRX, '0);
        tick();
        tick();
        check("abort_in_settle", 64'(bus.diagRead12x), 64'd1);
        resetN = 1'b0;
        tick();
        check("abort_req", 64'(bus.ebusReq), 64'd0);
        check("abort_diag", 64'(bus.diagRead12x), 64'd0);
        check("abort_valid", 64'(bus.rspValid), 64'd0);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_idle_req", 64'(bus.ebusReq), 64'd0);
            check("abort_idle_valid", 64'(bus.rspValid), 64'd0);
        end
        exp_q.push_back('{data: 36'o111111_222222, err: 1'b0});
        issue(1'b0, SEL_ARX, '0);
        run_rsp(SEL_ARX, '0, lat, diag_cyc, ovr_cyc);
        check("fresh_lat", 64'(lat), 64'd6);
        finish_rsp();

        // Every selector with random data
        for (int i = 0; i < 8; i++) begin
            d = {$urandom(), 4'($urandom())};
            bus.ebusData = d;
            exp_q.push_back('{data: d, err: 1'b0});
            issue(1'b0, sels[i], '0);
            run_rsp(sels[i], '0, lat, diag_cyc, ovr_cyc);
            check("sel_lat", 64'(lat), 64'd6);
            check("sel_diag_cyc", 64'(diag_cyc), 64'd5);
            finish_rsp();
        end

        tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
